// File: rtl/residual_stream_out.sv
// Residual output stage: captures x and attn frames, forms the saturating residual
// sum per element and streams it row-major over valid/ready. Define RESIDUAL_ADD_EN for the sum; otherwise attn passes through.
module residual_stream_out #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 16,
    parameter int E          = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [L*E*DATA_WIDTH-1:0]      x_in,
    input  logic [L*E*DATA_WIDTH-1:0]      attn_in,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_last_row,
    output logic                           m_last,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);

    localparam int N     = L * E;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]  buf_q [N];
    logic [DATA_WIDTH-1:0]  buf_d [N];
    logic [DATA_WIDTH-1:0]  elem_res [N];
    logic                   capture;
    logic                   xfer;
    logic                   at_last;

`ifdef RESIDUAL_ADD_EN
    // One guard bit is enough: the sum of two N-bit signed values fits in N+1 bits.
    function automatic logic [DATA_WIDTH-1:0] sat_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] sum;
        sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            if (sum[DATA_WIDTH]) begin
                sat_add = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                sat_add = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end else begin
            sat_add = sum[DATA_WIDTH-1:0];
        end
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elem_res[i] = sat_add(x_in[i*DATA_WIDTH +: DATA_WIDTH],
                                  attn_in[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end
`else
    logic unused_x;
    assign unused_x = ^x_in;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elem_res[i] = attn_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end
`endif

    assign capture = (state_q == S_IDLE) && in_valid;
    assign at_last = (idx_q == IDX_W'(N - 1));
    assign xfer    = (state_q == S_STREAM) && m_ready;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            buf_d[i] = capture ? elem_res[i] : buf_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    idx_d     = '0;
                    overrun_d = 1'b0;
                    state_d   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (in_valid) begin
                    overrun_d = 1'b1;
                end
                // The index holds on the final element so it never wraps inside a frame.
                if (xfer) begin
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    always_comb begin
        m_valid    = 1'b0;
        m_data     = '0;
        m_last_row = 1'b0;
        m_last     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_STREAM: begin
                m_valid    = 1'b1;
                m_data     = buf_q[idx_q];
                m_last_row = ((int'(idx_q) % E) == (E - 1));
                m_last     = at_last;
                busy       = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_residual_stream_out.sv
// Self-checking bench for residual_stream_out: table vectors for saturation corners,
// random frames against an arithmetic reference model, backpressure, overrun and reset cases.
module tb_residual_stream_out;

    localparam int DW = 16;
    localparam int L  = 16;
    localparam int E  = 16;
    localparam int N  = L * E;
`ifdef RESIDUAL_ADD_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [N*DW-1:0]   x_in;
    logic [N*DW-1:0]   attn_in;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic              m_last_row;
    logic              m_last;
    logic              busy;
    logic              done;
    logic              overrun;

    residual_stream_out #(.DATA_WIDTH(DW), .L(L), .E(E)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .x_in       (x_in),
        .attn_in    (attn_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last_row (m_last_row),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] a;
        logic [15:0] exp_sum;
        logic [15:0] exp_pass;
    } vec_t;

    vec_t        tbl [7];
    logic [15:0] x_arr [N];
    logic [15:0] a_arr [N];
    logic [15:0] exp_q [$];
    int          n_checks;
    int          n_pass;

    function automatic logic [15:0] ref_elem(input logic [15:0] x, input logic [15:0] a);
        int s;
        if (!ADD_EN) return a;
        s = int'($signed(x)) + int'($signed(a));
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packs the frame arrays onto the ports and pulses in_valid for one edge.
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            x_in[i*DW +: DW]    = x_arr[i];
            attn_in[i*DW +: DW] = a_arr[i];
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fillModel();
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(ref_elem(x_arr[i], a_arr[i]));
    endtask

    task automatic fillRandom();
        for (int i = 0; i < N; i++) begin
            x_arr[i] = 16'($urandom);
            a_arr[i] = 16'($urandom);
        end
        fillModel();
    endtask

    // Called at the negedge right after capture; receives one frame and checks it.
    task automatic collectFrame(input int ready_pct, input int ovr_idx, input int rst_idx);
        int          rx = 0;
        int          cycles = 0;
        bit          fin = 1'b0;
        bit          stall = 1'b0;
        bit          injected = 1'b0;
        logic [15:0] held = '0;
        while (!fin && cycles < 4000) begin
            m_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            if (in_valid) in_valid = 1'b0;
            #1;
            if (cycles == 0) checkOutput("latency_valid_busy_ovr", {m_valid, busy, overrun}, 3'b110);
            if (stall) checkOutput("stall_hold", {m_valid, m_data}, {1'b1, held});
            if (rst_idx >= 0 && rx == rst_idx) begin
                rst_n = 1'b0;
                #1;
                checkOutput("reset_mid_outputs",
                            {m_valid, m_data, m_last_row, m_last, busy, done, overrun}, 22'h0);
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    checkOutput("reset_no_done", {done, m_valid, busy}, 3'b000);
                end
                rst_n = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    #1;
                    checkOutput("post_reset_idle", {done, m_valid, busy}, 3'b000);
                end
                @(negedge clk);
                return;
            end
            if (ovr_idx >= 0 && rx == ovr_idx && !injected) begin
                x_in     = ~x_in;
                attn_in  = attn_in ^ {N{16'h5A5A}};
                in_valid = 1'b1;
                injected = 1'b1;
            end
            if (m_valid && m_ready) begin
                checkOutput($sformatf("data[%0d]", rx), m_data, (rx < N) ? exp_q[rx] : 16'hxxxx);
                checkOutput($sformatf("markers[%0d]", rx), {m_last_row, m_last},
                            {(rx % E) == (E - 1), rx == N - 1});
                if (m_last) fin = 1'b1;
                rx++;
            end
            stall = m_valid && !m_ready;
            held  = m_data;
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        checkOutput("frame_finished", fin, 1'b1);
        checkOutput("frame_count", rx, N);
        #1;
        checkOutput("done_pulse", {done, busy, m_valid}, 3'b100);
        checkOutput("overrun_flag", overrun, (ovr_idx >= 0));
        @(negedge clk);
        #1;
        checkOutput("done_clear", {done, busy}, 2'b00);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        m_ready  = 1'b0;
        x_in     = '0;
        attn_in  = '0;

        tbl[0] = '{16'h7000, 16'h2000, 16'h7FFF, 16'h2000};
        tbl[1] = '{16'h9000, 16'hA000, 16'h8000, 16'hA000};
        tbl[2] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0001};
        tbl[3] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0001};
        tbl[4] = '{16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF};
        tbl[5] = '{16'h1234, 16'h0001, 16'h1235, 16'h0001};
        tbl[6] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000};

        #12;
        checkOutput("reset_outputs", {m_valid, m_data, m_last_row, m_last, busy, done, overrun}, 22'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_no_valid", {m_valid, busy, done}, 3'b000);

        $display("[TB] basic sum frame");
        for (int i = 0; i < N; i++) begin
            x_arr[i] = 16'h0100;
            a_arr[i] = 16'(i);
        end
        fillModel();
        applyStimulus();
        collectFrame(100, -1, -1);

        $display("[TB] saturation table frame, back-to-back capture");
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            x_arr[i] = tbl[i % 7].x;
            a_arr[i] = tbl[i % 7].a;
            exp_q.push_back(ADD_EN ? tbl[i % 7].exp_sum : tbl[i % 7].exp_pass);
        end
        applyStimulus();
        collectFrame(100, -1, -1);

        $display("[TB] random frame with backpressure");
        fillRandom();
        applyStimulus();
        collectFrame(50, -1, -1);

        $display("[TB] overrun during stream");
        fillRandom();
        applyStimulus();
        collectFrame(60, 40, -1);

        $display("[TB] reset mid-frame");
        fillRandom();
        applyStimulus();
        collectFrame(50, -1, 100);

        $display("[TB] fresh frame after reset");
        fillRandom();
        applyStimulus();
        collectFrame(70, -1, -1);

        $display("[TB] constant frame 7000 + 2000");
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            x_arr[i] = 16'h7000;
            a_arr[i] = 16'h2000;
            exp_q.push_back(ADD_EN ? 16'h7FFF : 16'h2000);
        end
        applyStimulus();
        collectFrame(100, -1, -1);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
